// File: rtl/imem_load_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// imem_load_arbiter_pkg : shared processor definitions for the IMEM loader
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none
`ifndef IMEM_LOAD_ARBITER_PKG_SV
`define IMEM_LOAD_ARBITER_PKG_SV

package imem_load_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_FLUSH = 2'd2,
    ST_RUN   = 2'd3
  } state_t;

  localparam logic [31:0] c_END_MARKER           = 32'hFFFF_FFFF;
  localparam int          c_LOAD_TIMEOUT_DEFAULT = 50000;

endpackage

`endif
`default_nettype wire

// File: rtl/imem_load_arbiter_byte_word_packer.sv
// ---------------------------------------------------------------------------
// imem_load_arbiter_byte_word_packer : little-endian byte-to-word assembler
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module imem_load_arbiter_byte_word_packer (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        clear,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic [31:0] word,
  output logic [1:0]  byte_idx,
  output logic        word_ready
);

  logic [31:0] r_word;
  logic [1:0]  r_idx;
  logic        r_ready;

  // Right shift: after four bytes the first one lands in bits 7:0.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_word  <= 32'd0;
      r_idx   <= 2'd0;
      r_ready <= 1'b0;
    end else if (clear) begin
      r_word  <= 32'd0;
      r_idx   <= 2'd0;
      r_ready <= 1'b0;
    end else begin
      r_ready <= byte_valid && (r_idx == 2'd3);
      if (byte_valid) begin
        r_word <= {byte_data, r_word[31:8]};
        r_idx  <= r_idx + 2'd1;
      end
    end
  end

  assign word       = r_word;
  assign byte_idx   = r_idx;
  assign word_ready = r_ready;

endmodule

`default_nettype wire

// File: rtl/imem_load_arbiter.sv
// ---------------------------------------------------------------------------
// imem_load_arbiter : UART program loader sharing the instruction memory port
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module imem_load_arbiter
  import imem_load_arbiter_pkg::*;
#(
  parameter int ADDR_W       = 8,
  parameter int LOAD_TIMEOUT = c_LOAD_TIMEOUT_DEFAULT
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              load_start,
  input  logic              uart_valid,
  input  logic [7:0]        uart_data,
  input  logic              hazard_bolha,
  input  logic [31:0]       fetch_pc,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              imem_we,
  output logic              bolha,
  output logic              pc_reset,
  output logic              loading,
  output logic [ADDR_W:0]   word_count,
  output logic              load_error
);

  localparam int                c_TMO_W    = $clog2(LOAD_TIMEOUT + 1);
  localparam logic [c_TMO_W-1:0] c_TMO_LAST = c_TMO_W'(LOAD_TIMEOUT - 1);
  localparam logic [c_TMO_W-1:0] c_TMO_ONE  = c_TMO_W'(1);
  localparam logic [ADDR_W-1:0]  c_PTR_ONE  = ADDR_W'(1);
  localparam logic [ADDR_W:0]    c_CNT_ONE  = (ADDR_W + 1)'(1);

  state_t              r_state;
  logic [ADDR_W-1:0]   r_wptr;
  logic [ADDR_W:0]     r_count;
  logic                r_error;
  logic [c_TMO_W-1:0]  r_tmo;

  logic [31:0] w_word;
  logic [1:0]  w_idx;
  logic        w_ready;
  logic        w_in_load;
  logic        w_word_done;
  logic        w_marker;
  logic        w_write;
  logic        w_full;
  logic        w_tmo_hit;
  logic        w_unused_pc;

  assign w_in_load   = (r_state == ST_LOAD);
  assign w_word_done = w_in_load && w_ready;
  assign w_marker    = (w_word == c_END_MARKER);
  assign w_write     = w_word_done && !w_marker;
  assign w_full      = (r_wptr == {ADDR_W{1'b1}});
  // An arriving byte always beats the timeout in the same cycle.
  assign w_tmo_hit   = w_in_load && !uart_valid && (r_tmo == c_TMO_LAST);

  imem_load_arbiter_byte_word_packer u_packer (
    .clock      (clock),
    .reset_n    (reset_n),
    .clear      (!w_in_load),
    .byte_valid (w_in_load && uart_valid),
    .byte_data  (uart_data),
    .word       (w_word),
    .byte_idx   (w_idx),
    .word_ready (w_ready)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_wptr  <= '0;
      r_count <= '0;
      r_error <= 1'b0;
      r_tmo   <= '0;
    end else begin
      case (r_state)
        ST_IDLE, ST_RUN: begin
          r_tmo <= '0;
          if (load_start) begin
            r_state <= ST_LOAD;
            r_wptr  <= '0;
            r_count <= '0;
            r_error <= 1'b0;
          end
        end
        ST_LOAD: begin
          r_tmo <= uart_valid ? '0 : r_tmo + c_TMO_ONE;
          if (w_word_done) begin
            if (w_marker) begin
              r_state <= ST_FLUSH;
            end else begin
              r_wptr  <= r_wptr + c_PTR_ONE;
              r_count <= r_count + c_CNT_ONE;
              if (w_full) r_state <= ST_FLUSH;
            end
          end else if (w_tmo_hit) begin
            if (w_idx != 2'd0) begin
              r_error <= 1'b1;
              r_state <= ST_IDLE;
            end else if (r_count != '0) begin
              r_state <= ST_FLUSH;
            end else begin
              r_state <= ST_IDLE;
            end
          end
        end
        ST_FLUSH: begin
          r_tmo   <= '0;
          r_state <= ST_RUN;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign w_unused_pc = ^{fetch_pc[31:ADDR_W+2], fetch_pc[1:0]};

  assign imem_addr  = (r_state == ST_RUN) ? fetch_pc[ADDR_W+1:2] : r_wptr;
  assign imem_wdata = w_word;
  assign imem_we    = w_write;
  assign bolha      = (r_state == ST_RUN) ? hazard_bolha : 1'b1;
  assign pc_reset   = (r_state == ST_FLUSH);
  assign loading    = w_in_load;
  assign word_count = r_count;
  assign load_error = r_error;

endmodule

`default_nettype wire

// File: tb/tb_imem_load_arbiter.sv
// ---------------------------------------------------------------------------
// tb_imem_load_arbiter : scoreboard bench for the IMEM program loader
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_imem_load_arbiter;

  localparam int ADDR_W = 2;
  localparam int TMO    = 16;

  logic              clock = 1'b0;
  logic              reset_n;
  logic              load_start;
  logic              uart_valid;
  logic [7:0]        uart_data;
  logic              hazard_bolha;
  logic [31:0]       fetch_pc;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              imem_we;
  logic              bolha;
  logic              pc_reset;
  logic              loading;
  logic [ADDR_W:0]   word_count;
  logic              load_error;

  int n_pass  = 0;
  int n_total = 0;
  int pc_pulses = 0;
  logic [ADDR_W+31:0] exp_q[$];

  always #5 clock = ~clock;

  imem_load_arbiter #(.ADDR_W(ADDR_W), .LOAD_TIMEOUT(TMO)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .load_start   (load_start),
    .uart_valid   (uart_valid),
    .uart_data    (uart_data),
    .hazard_bolha (hazard_bolha),
    .fetch_pc     (fetch_pc),
    .imem_addr    (imem_addr),
    .imem_wdata   (imem_wdata),
    .imem_we      (imem_we),
    .bolha        (bolha),
    .pc_reset     (pc_reset),
    .loading      (loading),
    .word_count   (word_count),
    .load_error   (load_error)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Write monitor: every strobe must match the head of the expected queue.
  always @(negedge clock) begin
    if (reset_n) begin
      if (pc_reset) pc_pulses++;
      if (imem_we) begin
        if (exp_q.size() == 0) begin
          n_total++;
          $display("FAIL unexpected_write: got addr %0h data %h expected no write",
                   imem_addr, imem_wdata);
        end else begin
          chk("write", {imem_addr, imem_wdata}, exp_q.pop_front());
          chk("we_only_in_load", loading, 1'b1);
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(posedge clock); #1;
    uart_valid = 1'b1;
    uart_data  = b;
    @(posedge clock); #1;
    uart_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
  endtask

  task automatic pulse_load;
    @(posedge clock); #1;
    load_start = 1'b1;
    @(posedge clock); #1;
    load_start = 1'b0;
  endtask

  task automatic expect_write(input logic [ADDR_W-1:0] a, input logic [31:0] d);
    exp_q.push_back({a, d});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0; load_start = 1'b0; uart_valid = 1'b0; uart_data = 8'h00;
    hazard_bolha = 1'b0; fetch_pc = 32'h0;
    repeat (3) @(negedge clock);
    chk("rst_bolha", bolha, 1'b1);
    chk("rst_we", imem_we, 1'b0);
    chk("rst_pc_reset", pc_reset, 1'b0);
    chk("rst_loading", loading, 1'b0);
    chk("rst_word_count", word_count, 0);
    chk("rst_load_error", load_error, 1'b0);
    chk("rst_addr", imem_addr, 0);
    chk("rst_wdata", imem_wdata, 0);
    @(posedge clock); #1 reset_n = 1'b1;

    // Basic load: two words then end marker.
    pulse_load();
    @(negedge clock);
    chk("load_entered", loading, 1'b1);
    chk("load_bolha", bolha, 1'b1);
    expect_write(2'd0, 32'h0000_0013);
    expect_write(2'd1, 32'hDEAD_BEEF);
    send_word(32'h0000_0013);
    send_word(32'hDEAD_BEEF);
    send_word(32'hFFFF_FFFF);
    repeat (4) @(negedge clock);
    chk("load1_count", word_count, 2);
    chk("load1_pc_pulses", pc_pulses, 1);
    chk("load1_in_run", loading, 1'b0);

    // RUN: fetch address and transparent hazard stall; UART ignored.
    fetch_pc = 32'h0000_000C;
    for (int i = 0; i < 4; i++) begin
      @(posedge clock); #1 hazard_bolha = i[0];
      @(negedge clock);
      chk("run_addr", imem_addr, 3);
      chk("run_bolha", bolha, hazard_bolha);
    end
    send_word(32'h1234_5678);

    // Reload from RUN while no hazard stall.
    @(posedge clock); #1 hazard_bolha = 1'b0;
    @(negedge clock);
    chk("run_bolha_low", bolha, 1'b0);
    pulse_load();
    @(negedge clock);
    chk("reload_bolha", bolha, 1'b1);
    chk("reload_count_clr", word_count, 0);
    expect_write(2'd0, 32'hAABB_CCDD);
    send_word(32'hAABB_CCDD);
    send_word(32'hFFFF_FFFF);
    repeat (4) @(negedge clock);
    chk("reload_count", word_count, 1);
    chk("reload_pc_pulses", pc_pulses, 2);

    // Timeout with a partial word pending.
    pulse_load();
    send_byte(8'h01);
    send_byte(8'h02);
    repeat (TMO - 1) @(posedge clock);
    @(negedge clock);
    chk("tmo_not_yet", loading, 1'b1);
    @(posedge clock);
    @(negedge clock);
    chk("tmo_left_load", loading, 1'b0);
    chk("tmo_error", load_error, 1'b1);
    chk("tmo_bolha", bolha, 1'b1);
    chk("tmo_no_flush", pc_pulses, 2);

    // A byte on the exact timeout cycle keeps the load alive.
    pulse_load();
    @(negedge clock);
    chk("error_cleared", load_error, 1'b0);
    repeat (TMO - 2) @(posedge clock);
    send_byte(8'h44);
    @(negedge clock);
    chk("byte_beats_tmo", loading, 1'b1);
    expect_write(2'd0, 32'h1122_3344);
    send_byte(8'h33);
    send_byte(8'h22);
    send_byte(8'h11);
    send_word(32'hFFFF_FFFF);
    repeat (4) @(negedge clock);
    chk("edge_pc_pulses", pc_pulses, 3);

    // Fill the whole memory; the 5th word must be dropped.
    pulse_load();
    expect_write(2'd0, 32'h0A0B_0C0D);
    expect_write(2'd1, 32'h0000_0001);
    expect_write(2'd2, 32'h8000_0000);
    expect_write(2'd3, 32'hFFFF_FFFE);
    send_word(32'h0A0B_0C0D);
    send_word(32'h0000_0001);
    send_word(32'h8000_0000);
    send_word(32'hFFFF_FFFE);
    send_word(32'h5555_AAAA);
    repeat (3) @(negedge clock);
    chk("full_count", word_count, 4);
    chk("full_pc_pulses", pc_pulses, 4);
    chk("full_in_run", loading, 1'b0);

    // Asynchronous reset on the third byte of a word.
    pulse_load();
    send_byte(8'h10);
    send_byte(8'h20);
    @(posedge clock); #1;
    uart_valid = 1'b1;
    uart_data  = 8'h30;
    #2 reset_n = 1'b0;
    #1;
    chk("arst_bolha", bolha, 1'b1);
    chk("arst_loading", loading, 1'b0);
    chk("arst_we", imem_we, 1'b0);
    chk("arst_count", word_count, 0);
    chk("arst_addr", imem_addr, 0);
    chk("arst_wdata", imem_wdata, 0);
    uart_valid = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
    send_byte(8'h40);
    pulse_load();
    expect_write(2'd0, 32'h0000_0055);
    send_word(32'h0000_0055);
    send_word(32'hFFFF_FFFF);
    repeat (4) @(negedge clock);
    chk("post_rst_count", word_count, 1);
    chk("post_rst_pc_pulses", pc_pulses, 5);
    chk("queue_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/imem_load_arbiter.md
IMEM_LOAD_ARBITER -- requirements
Module: imem_load_arbiter

Interface
REQ-001 Parameter ADDR_W, default 8, instruction-memory word-address width.
REQ-002 Parameter LOAD_TIMEOUT, default 50000, idle cycles between bytes before a load is closed.
REQ-003 clock  input  1  single system clock; all state updates on posedge.
REQ-004 reset_n  input  1  asynchronous active-low reset.
REQ-005 load_start  input  1  request to enter program-load mode, level-sampled.
REQ-006 uart_valid  input  1  one-cycle pulse; uart_data holds a received byte.
REQ-007 uart_data  input  8  received byte.
REQ-008 hazard_bolha  input  1  stall request from the hazard unit.
REQ-009 fetch_pc  input  32  current fetch PC.
REQ-010 imem_addr  output  ADDR_W  instruction-memory word address.
REQ-011 imem_wdata  output  32  write data.
REQ-012 imem_we  output  1  write strobe.
REQ-013 bolha  output  1  stall to fetch.
REQ-014 pc_reset  output  1  one-cycle pulse forcing fetch PC to 0.
REQ-015 loading  output  1  high in LOAD.
REQ-016 word_count  output  ADDR_W+1  words written by the last or current load.
REQ-017 load_error  output  1  sticky: last load ended with a partial word.

Function
REQ-018 FSM states IDLE, LOAD, FLUSH, RUN; the state register is the only path to bolha, except in RUN.
REQ-019 IDLE: bolha=1; load_start=1 -> LOAD next cycle; word_count, byte index and word pointer cleared on entry to LOAD; load_error cleared on entry to LOAD.
REQ-020 LOAD: each uart_valid byte fills the shift word little-endian (byte 0 -> bits 7:0, byte 3 -> bits 31:24); the byte index wraps 3 -> 0.
REQ-021 On the 4th byte, if the assembled word is not 0xFFFFFFFF, imem_we=1 for exactly the next cycle with imem_addr=word pointer and imem_wdata=word; the pointer and word_count then increment.
REQ-022 Assembled word 0xFFFFFFFF is an end marker: it is not written; next state FLUSH.
REQ-023 A write to address 2^ADDR_W-1 ends the load (memory full): next state FLUSH; further bytes are ignored.
REQ-024 Timeout counter clears on every uart_valid and increments otherwise; when it reaches LOAD_TIMEOUT: byte index != 0 -> load_error=1, go to IDLE; byte index = 0 and word_count > 0 -> FLUSH; word_count = 0 -> IDLE.
REQ-025 load_start in LOAD is ignored.
REQ-026 FLUSH lasts exactly one cycle: bolha=1, pc_reset=1; next state RUN.
REQ-027 RUN: imem_we=0; imem_addr=fetch_pc[ADDR_W+1:2]; bolha=hazard_bolha (combinational); uart_valid ignored.
REQ-028 RUN with load_start=1: next state LOAD; bolha=1 from that next cycle onward.
REQ-029 Outside RUN, imem_addr is driven by the word pointer; imem_we is never asserted outside LOAD.
REQ-030 uart_valid in the same cycle as the LOAD timeout hit: the byte wins and the counter clears.

Reset
REQ-031 reset_n=0 forces IDLE immediately, asynchronously, including mid-LOAD and mid-write.
REQ-032 Reset values: bolha=1, imem_we=0, pc_reset=0, loading=0, word_count=0, load_error=0, imem_addr=0, imem_wdata=0, all counters 0.
REQ-033 A partial word is discarded on reset; no write is issued on reset release.

Structure
REQ-034 State encodings, the end-marker constant 0xFFFFFFFF and the default LOAD_TIMEOUT go in the shared processor definitions include with guard macro.
REQ-035 A byte-to-word assembler sub-module, byte_word_packer (shift register, byte index, word_ready pulse), is the one natural sub-module.

Verification
REQ-036 Reset, then load_start pulse and bytes 13 00 00 00, EF BE AD DE, FF FF FF FF -> writes 0x00000013 @0 and 0xDEADBEEF @1; word_count=2; a single pc_reset pulse; then RUN.
REQ-037 In RUN, fetch_pc=0x0000000C with hazard_bolha toggling -> imem_addr=3 and bolha equals hazard_bolha every cycle; imem_we=0.
REQ-038 LOAD with bytes 01 02, then silence for LOAD_TIMEOUT cycles -> load_error=1, state IDLE, no write, bolha=1.
REQ-039 With ADDR_W=2, send 4 non-marker words -> 4 writes @0..3, then FLUSH/RUN; a 5th word is ignored.
REQ-040 reset_n low on the cycle of the 3rd byte of word 1 -> outputs at reset values; a later load starts at address 0.
REQ-041 load_start in RUN while hazard_bolha=0 -> bolha=1 next cycle; a new load overwrites from address 0.
